// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO drain arbiter.
// The burst-mode option of the top level is selected by the FIFO_ARB_BURST_EN define.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_NUM_Q     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_LEN = 4;

    // Width of an index that selects one of n queues
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotating priority encoder: first asserted request at or after ptr, wrapping.
module rr_arb_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_Q = DEF_NUM_Q,
    parameter int IW    = idx_w(DEF_NUM_Q)
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [NUM_Q-1:0] gnt_onehot,
    output logic [IW-1:0]    gnt_idx,
    output logic             any
);

    // Scan from the farthest offset down so the nearest request to ptr is written last and wins
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        gnt_idx  = {IW{1'b0}};
        any      = 1'b0;
        cand     = 0;
        cand_idx = {IW{1'b0}};
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            cand     = int'(ptr) + k;
            cand     = (cand >= NUM_Q) ? (cand - NUM_Q) : cand;
            cand_idx = IW'(cand);
            gnt_idx  = req[cand_idx] ? cand_idx : gnt_idx;
            any      = any | req[cand_idx];
        end
    end

    // One-hot form of the winning index
    always_comb begin
        if (any) begin
            gnt_onehot = {{(NUM_Q-1){1'b0}}, 1'b1} << gnt_idx;
        end else begin
            gnt_onehot = {NUM_Q{1'b0}};
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain scheduler: pops one word at a time from a bank of FIFO4 queues onto a
// single valid/ready stream tagged with its source index. Burst mode: define FIFO_ARB_BURST_EN.
module fifo_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_Q     = DEF_NUM_Q,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_Q-1:0]          q_empty,
    input  logic [NUM_Q*DATA_W-1:0]   q_data,
    output logic [NUM_Q-1:0]          q_pop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(NUM_Q)-1:0]  out_src
);

    localparam int            IW       = idx_w(NUM_Q);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_Q - 1);

    if (NUM_Q < 2 || NUM_Q > 8) begin : g_bad_num_q
        $error("fifo_drain_arbiter: NUM_Q must be in 2..8");
    end
    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("fifo_drain_arbiter: BURST_LEN must be at least 1");
    end

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IW-1:0]      rr_ptr_r;
    logic [IW-1:0]      pick_ptr_s;
    logic [IW-1:0]      win_idx_s;
    logic [IW-1:0]      rr_nxt_s;
    logic [NUM_Q-1:0]   req_s;
    logic [NUM_Q-1:0]   gnt_onehot_s;
    logic               any_s;
    logic               free_s;
    logic               grant_s;
    logic               out_valid_r;
    logic [DATA_W-1:0]  out_data_r;
    logic [IW-1:0]      out_src_r;
    logic [DATA_W-1:0]  q_word_s [NUM_Q];

    assign req_s   = ~q_empty;
    // The output register is free when idle or when its word leaves this cycle
    assign free_s  = (state_r == IDLE) || (out_valid_r && out_ready);
    assign grant_s = !reset && en && any_s && free_s;
    assign rr_nxt_s = (win_idx_s == LAST_IDX) ? {IW{1'b0}} : (win_idx_s + IW'(1));

`ifdef FIFO_ARB_BURST_EN
    localparam int            BW        = $clog2(BURST_LEN) + 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN - 1);

    logic [BW-1:0] burst_cnt_r;
    logic [IW-1:0] burst_src_r;
    logic          burst_act_r;
    logic          hold_s;

    // burst_cnt_r counts repeat grants after the first one, so BURST_MAX repeats make BURST_LEN
    assign hold_s     = burst_act_r && (burst_cnt_r < BURST_MAX) && !q_empty[burst_src_r];
    assign pick_ptr_s = hold_s ? burst_src_r : rr_ptr_r;

    // Burst tracking: extend on a held grant, restart on rotation, drop when the queue empties
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_r <= {BW{1'b0}};
            burst_src_r <= {IW{1'b0}};
            burst_act_r <= 1'b0;
        end else if (grant_s) begin
            burst_act_r <= 1'b1;
            burst_src_r <= win_idx_s;
            burst_cnt_r <= hold_s ? (burst_cnt_r + BW'(1)) : {BW{1'b0}};
        end else if (q_empty[burst_src_r]) begin
            burst_act_r <= 1'b0;
            burst_cnt_r <= {BW{1'b0}};
        end
    end
`else
    assign pick_ptr_s = rr_ptr_r;
`endif

    rr_arb_pick #(
        .NUM_Q (NUM_Q),
        .IW    (IW)
    ) u_pick (
        .req        (req_s),
        .ptr        (pick_ptr_s),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (win_idx_s),
        .any        (any_s)
    );

    // Unpack the flat queue data bus into per-queue words
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            q_word_s[i] = q_data[i*DATA_W +: DATA_W];
        end
    end

    // Next-state and pop pulse
    always_comb begin
        state_nxt_s = state_r;
        q_pop       = {NUM_Q{1'b0}};
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (grant_s) begin
                    state_nxt_s = SEND;
                end else if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (grant_s) begin
            q_pop = gnt_onehot_s;
        end else begin
            q_pop = {NUM_Q{1'b0}};
        end
    end

    // State, round-robin pointer and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {IW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_src_r   <= {IW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                out_data_r  <= q_word_s[win_idx_s];
                out_src_r   <= win_idx_s;
                out_valid_r <= 1'b1;
                rr_ptr_r    <= rr_nxt_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter: behavioural FIFO4 queues feed the DUT, expected
// words are queued by the stimulus and consumed by a negedge monitor on each handshake.
module tb_fifo_drain_arbiter;

    localparam int NQ = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              out_ready;
    logic              out_valid;
    logic [NQ-1:0]     q_empty;
    logic [NQ-1:0]     q_pop;
    logic [NQ*DW-1:0]  q_data;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_src;

    int          errors   = 0;
    int          checks   = 0;
    int          hs_count = 0;
    logic [9:0]  exp_q [$];
    logic [7:0]  mem [NQ][16];
    int          hd [NQ];
    int          tl [NQ];
    logic [NQ-1:0] pend = 4'b0000;

    logic [1:0] t2_src  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] t2_data [8] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1, 8'hB1, 8'hC1, 8'hD1};
    logic [1:0] t6_src  [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                 2'd0, 2'd0, 2'd1, 2'd1};
    logic [7:0] t6_data [12] = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h71, 8'h72, 8'h73,
                                 8'h64, 8'h65, 8'h74, 8'h75};

    always #5 clk = ~clk;

    fifo_drain_arbiter #(.NUM_Q(NQ), .DATA_W(DW), .BURST_LEN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .q_empty   (q_empty),
        .q_data    (q_data),
        .q_pop     (q_pop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    for (genvar g = 0; g < NQ; g++) begin : g_fifo
        assign q_empty[g]          = (hd[g] == tl[g]);
        assign q_data[g*DW +: DW]  = mem[g][hd[g] % 16];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int q, input logic [7:0] d);
        mem[q][tl[q] % 16] = d;
        tl[q] = tl[q] + 1;
    endtask

    task automatic expect_word(input logic [1:0] s, input logic [7:0] d);
        exp_q.push_back({s, d});
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: record pops for the queue model and score every accepted word
    always @(negedge clk) begin
        logic [9:0] e;
        pend = q_pop;
        for (int i = 0; i < NQ; i++) begin
            if (q_pop[i] && hd[i] == tl[i]) begin
                checks++;
                errors++;
                $display("FAIL pop_empty: queue %0d popped while empty", i);
            end
        end
        if (!reset && out_valid && out_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got src=%0d data=0x%0h, want none", out_src, out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_word", {22'd0, out_src, out_data}, {22'd0, e});
            end
        end
    end

    // Queue model: a pop takes effect just after the edge that sampled it
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (pend[i] && hd[i] != tl[i]) begin
                hd[i] = hd[i] + 1;
            end
        end
    end

    initial begin
        int hs0;
        for (int i = 0; i < NQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        reset = 1'b1;
        en = 1'b0;
        out_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);

        // 1: all queues empty, grants enabled -> nothing happens
        cyc();
        reset = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("t1_pop", 32'(q_pop), 32'd0);
            check("t1_valid", 32'(out_valid), 32'd0);
        end

        // 2: four queues of two words, full round-robin with wrap at one word per cycle
        cyc();
        for (int k = 0; k < 8; k++) begin
            push_word(int'(t2_src[k]), t2_data[k]);
            expect_word(t2_src[k], t2_data[k]);
        end
        hs0 = hs_count;
        repeat (9) cyc();
        check("t2_rate", 32'(hs_count - hs0), 32'd8);
        wait_drain(10, "t2_drain");

        // 3: backpressure holds word 0x5C; release pops the next queue in the same cycle
        cyc();
        out_ready = 1'b0;
        push_word(0, 8'h5C);
        push_word(1, 8'h77);
        expect_word(2'd0, 8'h5C);
        expect_word(2'd1, 8'h77);
        @(negedge clk);
        check("t3_first_pop", 32'(q_pop), 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_hold_data", 32'(out_data), 32'h5C);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_pop", 32'(q_pop), 32'd0);
        end
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_pop", 32'(q_pop), 32'h2);
        wait_drain(10, "t3_drain");

        // 4: single busy queue granted every cycle, then return to idle
        cyc();
        push_word(2, 8'h21);
        push_word(2, 8'h22);
        push_word(2, 8'h23);
        expect_word(2'd2, 8'h21);
        expect_word(2'd2, 8'h22);
        expect_word(2'd2, 8'h23);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_pop", 32'(q_pop), 32'h4);
        end
        @(negedge clk);
        check("t4_no_pop", 32'(q_pop), 32'd0);
        check("t4_last_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("t4_idle_valid", 32'(out_valid), 32'd0);
        wait_drain(5, "t4_drain");

        // 5a: en falls while a word is held; it still completes and nothing new is granted
        cyc();
        out_ready = 1'b0;
        push_word(1, 8'h31);
        push_word(1, 8'h32);
        expect_word(2'd1, 8'h31);
        @(negedge clk);
        check("t5_grant", 32'(q_pop), 32'h2);
        cyc();
        en = 1'b0;
        @(negedge clk);
        check("t5_en_off_pop", 32'(q_pop), 32'd0);
        check("t5_en_off_valid", 32'(out_valid), 32'd1);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_en_off_hs_pop", 32'(q_pop), 32'd0);
        cyc();
        @(negedge clk);
        check("t5_en_off_idle", 32'(out_valid), 32'd0);
        wait_drain(5, "t5a_drain");

        // 5b: reset while a word is in flight; rr_ptr restarts at queue 0
        cyc();
        en = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_refill_pop", 32'(q_pop), 32'h2);
        cyc();
        reset = 1'b1;
        out_ready = 1'b1;
        push_word(2, 8'h42);
        push_word(0, 8'h40);
        @(negedge clk);
        check("t5_rst_pop", 32'(q_pop), 32'd0);
        cyc();
        @(negedge clk);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_pop2", 32'(q_pop), 32'd0);
        check("t5_rr_ptr", 32'(dut.rr_ptr_r), 32'd0);
        cyc();
        reset = 1'b0;
        expect_word(2'd0, 8'h40);
        expect_word(2'd2, 8'h42);
        wait_drain(10, "t5b_drain");

`ifdef FIFO_ARB_BURST_EN
        // 6: burst of four per queue, rotation when a queue runs dry
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            push_word(int'(t6_src[k]), t6_data[k]);
            expect_word(t6_src[k], t6_data[k]);
        end
        wait_drain(20, "t6_drain");
`endif

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
